// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  localparam int WORD_BYTES = 4;

  typedef logic [15:0] len_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a big-endian byte stream into 32-bit words and keeps a running XOR
// of every byte it has taken since the last clear.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  logic [1:0]  byte_idx;
  logic [23:0] shift;

  // The 4th byte completes the word in the same cycle; the caller registers it.
  assign word_valid = byte_valid && (byte_idx == 2'(WORD_BYTES - 1));
  assign word       = {shift, byte_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= '0;
      shift    <= '0;
      csum     <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      shift    <= '0;
      csum     <= '0;
    end else if (byte_valid) begin
      byte_idx <= byte_idx + 2'd1;
      shift    <= {shift[15:0], byte_data};
      csum     <= csum ^ byte_data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length/data/checksum frame, writes words into the
// instruction memory, and releases the core only after a clean load.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | no load attempted since reset
// ST_LEN_HI | waiting for word count [15:8]
// ST_LEN_LO | waiting for word count [7:0], range check
// ST_DATA   | streaming instruction bytes, writing words
// ST_CSUM   | waiting for XOR checksum byte
// ST_DONE   | load good, core running
// ST_ERROR  | load failed (range, checksum or timeout)
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [16:0]     CAPACITY = 17'(1) << ADDR_W;

  loader_state_t    state, state_nx;
  logic [7:0]       len_hi;
  len_t             len, len_rx;
  logic [CNT_W-1:0] idle_cnt;
  logic             xfer, start_ok, data_byte, last_word, timed_out;
  logic             word_valid;
  logic [31:0]      word;
  logic [7:0]       csum;

  assign busy      = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                     (state == ST_DATA)   || (state == ST_CSUM);
  assign rx_ready  = busy;
  assign done      = (state == ST_DONE);
  assign error     = (state == ST_ERROR);
  assign cpu_run   = (state == ST_DONE);

  assign xfer      = rx_valid && rx_ready;
  assign start_ok  = start && !busy;
  assign data_byte = xfer && (state == ST_DATA);
  assign len_rx    = {len_hi, rx_data};
  assign last_word = ({1'b0, len} == (17'(words_loaded) + 17'd1));
  // Down-counter expires on the cycle its terminal count would be passed.
  assign timed_out = busy && !xfer && (idle_cnt == '0);

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_valid (data_byte),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word),
    .csum       (csum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_nx = ST_LEN_HI;
      ST_LEN_HI: if (xfer) state_nx = ST_LEN_LO;
      ST_LEN_LO: if (xfer) begin
        if ({1'b0, len_rx} > CAPACITY) state_nx = ST_ERROR;
        else if (len_rx == '0)         state_nx = ST_CSUM;
        else                           state_nx = ST_DATA;
      end
      ST_DATA: if (word_valid && last_word) state_nx = ST_CSUM;
      ST_CSUM: if (xfer) state_nx = (rx_data == csum) ? ST_DONE : ST_ERROR;
      default: state_nx = ST_IDLE;
    endcase
    if (timed_out) state_nx = ST_ERROR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      len_hi       <= '0;
      len          <= '0;
      idle_cnt     <= CNT_LOAD;
    end else begin
      imem_we <= word_valid;
      if (start_ok) begin
        words_loaded <= '0;
        len_hi       <= '0;
        len          <= '0;
        idle_cnt     <= CNT_LOAD;
      end else begin
        if (busy) idle_cnt <= xfer ? CNT_LOAD : idle_cnt - 1'b1;
        if (xfer && state == ST_LEN_HI) len_hi <= rx_data;
        if (xfer && state == ST_LEN_LO) len    <= len_rx;
        // Address and data are held after the strobe so the memory sees stable values.
        if (word_valid) begin
          imem_addr    <= words_loaded[ADDR_W-1:0];
          imem_wdata   <= word;
          words_loaded <= words_loaded + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the MIPS single-cycle core's instruction memory. It receives a framed byte stream of 16-bit big-endian word count, 4·N instruction bytes and an XOR checksum byte. It assembles the bytes into 32-bit words and writes them sequentially into the instruction-memory write port. The core is held in reset until a load completes with a valid checksum.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction-memory word-address width. Capacity is 2^ADDR_W words.
- `TIMEOUT`, default 1_000_000: maximum idle cycles allowed between accepted bytes while a frame is open.

Ports:
- `clk`, in, 1: single clock for the block.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that opens a new load. Honoured only in IDLE, DONE or ERROR.
- `rx_data`, in, 8: stream byte.
- `rx_valid`, in, 1: `rx_data` is valid.
- `rx_ready`, out, 1: loader can accept a byte. A transfer occurs on `rx_valid & rx_ready`.
- `imem_we`, out, 1: one-cycle write strobe to the instruction memory.
- `imem_addr`, out, ADDR_W: word address of the write.
- `imem_wdata`, out, 32: instruction word.
- `cpu_run`, out, 1: high means the core may run. Integration drives core `reset = ~cpu_run`.
- `busy`, out, 1: a frame is open.
- `done`, out, 1: last load succeeded.
- `error`, out, 1: last load failed.
- `words_loaded`, out, ADDR_W+1: count of words written in the current or last load.

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR.
- IDLE/DONE/ERROR → LEN_HI on `start`. On this transition, clear `words_loaded`, the byte index, the checksum accumulator, `done` and `error`. `cpu_run` goes to 0.
- LEN_HI: accepted byte → len[15:8]; go to LEN_LO.
- LEN_LO: accepted byte → len[7:0]. Then:
  - len > 2^ADDR_W → ERROR.
  - len == 0 → CSUM.
  - otherwise → DATA.
- DATA: bytes are big-endian; the first byte of each word goes to [31:24].
  - Every data byte is XORed into an 8-bit accumulator. Length bytes are not included.
  - On the 4th byte of word k, issue the write: `imem_addr = k`, `imem_wdata = word`, and increment `words_loaded`.
  - After word len-1 → CSUM.
- CSUM: accepted byte == accumulator → DONE, otherwise → ERROR.
- DONE: `done = 1`, `cpu_run = 1`. State holds until `start` or reset.
- ERROR: `error = 1`, `cpu_run = 0`. Words already written are not rolled back.
- Timeout: in LEN_HI, LEN_LO, DATA or CSUM, an idle counter increments each cycle with no transfer and resets on any transfer. When it reaches TIMEOUT → ERROR.
- `rx_ready = busy`. Both are decoded from the state register only, with no combinational path from `rx_valid`.
- `start` is ignored while busy. Bytes presented outside a frame are not accepted.

## Timing
- Reset values: state IDLE; `rx_ready`, `imem_we`, `cpu_run`, `busy`, `done`, `error` all 0; `imem_addr`, `imem_wdata`, `words_loaded` all 0.
- `imem_we` is registered and asserted the cycle after the 4th byte is accepted, for exactly one cycle. `imem_addr`/`imem_wdata` are stable in that cycle and held afterwards.
- The CSUM byte is accepted in cycle t. In cycle t+1 the state is DONE/ERROR and `done`/`error`/`cpu_run` are valid.
- Full throughput is one byte per cycle with no bubbles, so the fastest load takes 2 + 4N + 1 accept cycles.
- Timeout: if the last accepted byte is in cycle t, `error` is high in cycle t+TIMEOUT+1.
- A transfer and a timeout expiry in the same cycle: the transfer wins.
- Reset asserted mid-load: immediate return to IDLE with all outputs at reset values. A partially written imem is left as is.
- `words_loaded` saturates only by construction, because len is bounded by 2^ADDR_W.

## Structure
- `loader_pkg`:
  - `loader_state_t` enum.
  - `WORD_BYTES = 4` constant.
  - 16-bit length type.
- Sub-module `word_assembler`: shifts in bytes, tracks the byte index (0–3), outputs `word_valid` pulse plus `word`, and maintains the XOR accumulator. It is cleared on `start`.
- The FSM, timeout counter and address counter stay in `imem_loader`.

## Test plan
1. Valid 2-word load: stream 00 02 20 08 00 05 20 09 00 0A 0E.
   - Writes addr0 = 0x20080005 and addr1 = 0x2009000A, one `imem_we` pulse each.
   - `done = 1`, `cpu_run = 1`, `words_loaded = 2`.
2. Bad checksum: same stream with final byte 0F.
   - Both writes still occur.
   - `error = 1`, `done = 0`, `cpu_run = 0` the cycle after CSUM.
3. Empty program: stream 00 00 00 → no `imem_we`, `done = 1`, `words_loaded = 0`.
4. Overflow with ADDR_W = 8: stream 01 01.
   - ERROR the cycle after the 2nd byte; `rx_ready` drops; no writes.
5. Timeout with TIMEOUT = 16: send 00 01 20 08 00, then hold `rx_valid = 0`.
   - `error` rises exactly 17 cycles after the last accept; no write.
6. Backpressure, restart and reset:
   - Random `rx_valid` gaps shorter than TIMEOUT → same result as scenario 1.
   - `start` from ERROR reloads successfully.
   - Asserting `reset` low during DATA returns all outputs to 0 asynchronously.
